sfx_voice_mixer: RTL
====================

Name: sfx_voice_mixer

Overview:
- Multi-voice sound-effect player: sits between the per-sound sample ROMs and audio_codec, replacing the single-sound fetcher.
- Per voice: ROM address walk, start/stop/loop control and volume shift.
- Mixes all voices with saturation and presents one 16-bit sample per codec sample_req.
- Runs in the audio_clk domain; trig/stop/loop/vol arrive already synchronised from the Avalon register block.

Parameters:
- NUM_VOICES, 2, number of voices/ROMs mixed.
- ADDR_W, 15, ROM address width.
- ROM_LAT, 2, cycles from rom_addr change to valid rom_q.

Ports:
- clk  in  1  audio_clk.
- resetn  in  1  reset, synchronous, active-low.
- sample_req  in  1  codec request pulse (1 cycle); audio_output is sampled the cycle after.
- trig  in  NUM_VOICES  1-cycle pulse; start/restart voice i from address 0.
- stop  in  NUM_VOICES  1-cycle pulse; deactivate voice i.
- loop_en  in  NUM_VOICES  level; voice wraps instead of ending.
- vol_shift  in  2*NUM_VOICES  arithmetic right-shift 0..3 per voice.
- voice_len  in  ADDR_W*NUM_VOICES  sample count per voice (>=1; static).
- rom_addr  out  ADDR_W*NUM_VOICES  ROM address per voice.
- rom_q  in  16*NUM_VOICES  signed ROM data per voice.
- audio_output  out  16  signed mixed sample to codec.
- voice_done  out  NUM_VOICES  1-cycle pulse when a non-looping voice ends (feeds irq).
- overrun  out  1  sticky: sample_req arrived while the mix was incomplete.

Behaviour:
- Reset (resetn=0 at a clk edge): audio_output=0, mix_q=0, rom_addr=0, active=0, pos=0, voice_done=0, overrun=0, FSM=IDLE. Applies mid-operation with no residue.
- Output pipeline: on a sample_req cycle, audio_output <= mix_q at the next edge.
- FSM then computes the next mix_q, giving one sample period of latency.
- FSM states:
  - IDLE: on sample_req go to ADDR.
  - ADDR: rom_addr[i] = pos[i]; hold for ROM_LAT cycles (counter), then go to ACC with acc=0, i=0.
  - ACC: one voice per cycle; acc += active[i] ? (rom_q[i] >>> vol_shift[i]) : 0; after i=NUM_VOICES-1 go to SAT.
  - SAT: mix_q = clamp(acc, -32768, 32767), go to ADV.
  - ADV: update each active voice, then go to IDLE. If pos==voice_len-1 and loop_en: pos=0. If pos==voice_len-1 and !loop_en: active=0, pos=0, voice_done[i]=1 for one cycle. Otherwise pos+1.
- Total busy = 1+ROM_LAT+NUM_VOICES+2 cycles.
- acc width: 16+$clog2(NUM_VOICES)+1, signed, sign-extended.
- trig/stop are honoured in any state and override ADV for that voice in the same cycle.
  - trig: active=1, pos=0.
  - stop: active=0, pos=0.
  - trig and stop in the same cycle: trig wins.
  - trig on an active voice restarts it; no voice_done.
- Voice changes during ACC affect only voices not yet accumulated.
- sample_req while FSM != IDLE: audio_output still <= mix_q (stale value), overrun=1 (cleared only by reset), current computation continues, request not queued.
- voice_len=1 non-loop: plays one sample then done.

Decomposition:
- Shared package sfx_pkg: state enum (IDLE, ADDR, ACC, SAT, ADV), saturating-clamp function, default ROM_LAT/ADDR_W constants.
- Sub-module sfx_voice (one per voice, generate loop): holds active/pos and handles trig/stop/advance/done.
- Mixer FSM and saturation stay in the top.

Test Plan (ROM model: q = addr*100, latency ROM_LAT; sample_req every 256 cycles unless noted):
- Reset hold 4 cycles then release -> audio_output=0, rom_addr=0, voice_done=0, overrun=0; successive sample_req with no trig -> outputs all 0.
- Voice0 len=4, loop=0, vol=0, trig before first req -> outputs 0,0,100,200,300,0; voice_done[0] pulses once, exactly 1 cycle.
- Voice0 len=3, loop=1 -> outputs 0,0,100,200,0,100,200; no voice_done; then stop -> output 0 from the second following req.
- Saturation:
  - Both voices constant 0x7000 -> audio_output 0x7FFF.
  - Both 0x9000 -> 0x8000.
  - 0x4000 with vol_shift=2 -> 0x1000.
  - 0xC000 with vol_shift=2 -> 0xF000.
- trig and stop on the same cycle -> voice active, pos=0. trig during ADV of the last sample -> restart, no done pulse.
- sample_req every 3 cycles -> overrun=1 sticky, audio_output repeats the last mix_q. Reset asserted in ACC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sfx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sfx_pkg
// Brief   : Shared types, defaults and the saturating clamp for the SFX mixer.
// Revision: 1.0 - initial release
// ============================================================================
package sfx_pkg;

    localparam int c_ADDR_W_DEFAULT  = 15;
    localparam int c_ROM_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_ACC  = 3'd2,
        ST_SAT  = 3'd3,
        ST_ADV  = 3'd4
    } mix_state_e;

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'h7FFF;
        end else if (v < -32'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfx_voice.sv
`default_nettype none
// ============================================================================
// Module  : sfx_voice
// Brief   : One voice: active flag, ROM position, trig/stop/advance and done.
// Revision: 1.0 - initial release
// ============================================================================
module sfx_voice
    import sfx_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              trig,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              advance,
    input  logic [ADDR_W-1:0] voice_len,
    output logic              active,
    output logic [ADDR_W-1:0] pos,
    output logic              done
);

    logic              r_active;
    logic [ADDR_W-1:0] r_pos;
    logic              r_done;

    // trig beats stop, and both beat the end-of-period advance
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_active <= 1'b0;
            r_pos    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (trig) begin
                r_active <= 1'b1;
                r_pos    <= '0;
            end else if (stop) begin
                r_active <= 1'b0;
                r_pos    <= '0;
            end else if (advance && r_active) begin
                if (r_pos == voice_len - 1'b1) begin
                    r_pos <= '0;
                    if (!loop_en) begin
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end else begin
                    r_pos <= r_pos + 1'b1;
                end
            end
        end
    end

    assign active = r_active;
    assign pos    = r_pos;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: rtl/sfx_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module  : sfx_voice_mixer
// Brief   : Multi-voice sample player; mixes voices with saturation per sample_req.
// Revision: 1.0 - initial release
// ============================================================================
module sfx_voice_mixer
    import sfx_pkg::*;
#(
    parameter int NUM_VOICES = 2,
    parameter int ADDR_W     = c_ADDR_W_DEFAULT,
    parameter int ROM_LAT    = c_ROM_LAT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         sample_req,
    input  logic [NUM_VOICES-1:0]        trig,
    input  logic [NUM_VOICES-1:0]        stop,
    input  logic [NUM_VOICES-1:0]        loop_en,
    input  logic [2*NUM_VOICES-1:0]      vol_shift,
    input  logic [ADDR_W*NUM_VOICES-1:0] voice_len,
    output logic [ADDR_W*NUM_VOICES-1:0] rom_addr,
    input  logic [16*NUM_VOICES-1:0]     rom_q,
    output logic signed [15:0]           audio_output,
    output logic [NUM_VOICES-1:0]        voice_done,
    output logic                         overrun
);

    localparam int c_ACC_W = 16 + $clog2(NUM_VOICES) + 1;
    localparam int c_IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int c_CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    mix_state_e                   r_state;
    mix_state_e                   w_state_next;
    logic [c_CNT_W-1:0]           r_lat_cnt;
    logic [c_IDX_W-1:0]           r_idx;
    logic signed [c_ACC_W-1:0]    r_acc;
    logic signed [c_ACC_W-1:0]    w_term;
    logic signed [15:0]           w_shifted;
    logic [15:0]                  r_mix_q;
    logic [15:0]                  r_audio;
    logic                         r_overrun;
    logic [ADDR_W*NUM_VOICES-1:0] r_rom_addr;
    logic [ADDR_W*NUM_VOICES-1:0] w_pos_flat;
    logic [NUM_VOICES-1:0]        w_active;
    logic                         w_adv;
    logic signed [15:0]           w_rom_q [NUM_VOICES];
    logic [1:0]                   w_vol   [NUM_VOICES];

    assign w_adv = (r_state == ST_ADV);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign w_rom_q[gi] = rom_q[gi*16 +: 16];
            assign w_vol[gi]   = vol_shift[gi*2 +: 2];

            sfx_voice #(
                .ADDR_W(ADDR_W)
            ) u_voice (
                .clk      (clk),
                .resetn   (resetn),
                .trig     (trig[gi]),
                .stop     (stop[gi]),
                .loop_en  (loop_en[gi]),
                .advance  (w_adv),
                .voice_len(voice_len[gi*ADDR_W +: ADDR_W]),
                .active   (w_active[gi]),
                .pos      (w_pos_flat[gi*ADDR_W +: ADDR_W]),
                .done     (voice_done[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (sample_req) w_state_next = ST_ADDR;
            ST_ADDR: if (r_lat_cnt == c_CNT_W'(ROM_LAT - 1)) w_state_next = ST_ACC;
            ST_ACC:  if (r_idx == c_IDX_W'(NUM_VOICES - 1)) w_state_next = ST_SAT;
            ST_SAT:  w_state_next = ST_ADV;
            ST_ADV:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Active is sampled per voice at its own ACC slot, so late trig/stop only reach later voices
    always_comb begin
        w_shifted = w_rom_q[r_idx] >>> w_vol[r_idx];
        w_term    = '0;
        if (w_active[r_idx]) begin
            w_term = {{(c_ACC_W-16){w_shifted[15]}}, w_shifted};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_audio    <= '0;
            r_mix_q    <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_lat_cnt  <= '0;
            r_overrun  <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            // A request while busy still gets the last finished mix; it is not queued
            if (sample_req) begin
                r_audio <= r_mix_q;
                if (r_state != ST_IDLE) r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (sample_req) begin
                        r_lat_cnt  <= '0;
                        r_rom_addr <= w_pos_flat;
                    end
                end
                ST_ADDR: begin
                    r_lat_cnt <= r_lat_cnt + 1'b1;
                    r_acc     <= '0;
                    r_idx     <= '0;
                end
                ST_ACC: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + 1'b1;
                end
                ST_SAT: begin
                    r_mix_q <= sat16({{(32-c_ACC_W){r_acc[c_ACC_W-1]}}, r_acc});
                end
                default: ;
            endcase
        end
    end

    assign audio_output = r_audio;
    assign rom_addr     = r_rom_addr;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire
